pong_paddle_mover: RTL and testbench

Parametrised paddle controller for the Pong game, generalising the single-speed, button-only paddle. It sits between the debounced switch inputs, ball position and VGA divided counters on one side and the Pong top-level draw mux on the other. It moves one paddle vertically with a slow-to-fast speed ramp. In auto mode it tracks the ball instead of the buttons. It emits a registered draw flag for the paddle column.

---
 rtl/pong_paddle_mover_if.sv | 40 ++++
 rtl/pong_paddle_mover.sv | 166 ++++++++++++++++
 tb/tb_pong_paddle_mover.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pong_paddle_mover_if.sv
// pong_paddle_mover_if
//   Groups the paddle controller's game-side signals into one bundle.
//   master : the producer side (switch debouncers, ball logic, VGA counters)
//            drives the requests and pixel position and reads the results.
//   slave  : the paddle controller itself.
//   Members:
//     i_Mode           0 = manual (buttons), 1 = auto (track ball)
//     i_Paddle_Up      debounced up button
//     i_Paddle_Dn      debounced down button
//     i_Ball_Y         ball row, used in auto mode
//     i_Col_Count_Div  current game-unit column
//     i_Row_Count_Div  current game-unit row
//     o_Draw_Paddle    registered: current pixel lies on the paddle
//     o_Paddle_Y       top row of the paddle
//     o_Step           one-cycle pulse in the cycle after Y changes
interface pong_paddle_mover_if #(
  parameter int COORD_W = 6
);
  logic               i_Mode;
  logic               i_Paddle_Up;
  logic               i_Paddle_Dn;
  logic [COORD_W-1:0] i_Ball_Y;
  logic [COORD_W-1:0] i_Col_Count_Div;
  logic [COORD_W-1:0] i_Row_Count_Div;
  logic               o_Draw_Paddle;
  logic [COORD_W-1:0] o_Paddle_Y;
  logic               o_Step;

  modport master (
    output i_Mode, i_Paddle_Up, i_Paddle_Dn, i_Ball_Y,
           i_Col_Count_Div, i_Row_Count_Div,
    input  o_Draw_Paddle, o_Paddle_Y, o_Step
  );

  modport slave (
    input  i_Mode, i_Paddle_Up, i_Paddle_Dn, i_Ball_Y,
           i_Col_Count_Div, i_Row_Count_Div,
    output o_Draw_Paddle, o_Paddle_Y, o_Step
  );
endinterface

// File: rtl/pong_paddle_mover.sv
// pong_paddle_mover
//   Moves one Pong paddle vertically with a slow-to-fast speed ramp. In
//   manual mode the debounced buttons steer it; in auto mode it steers its
//   centre row toward the ball row. A registered draw flag tells the draw
//   mux when the current game-unit pixel lies on the paddle.
//   Ports:
//     i_Clk       system clock (single clock domain)
//     i_Rst       synchronous, active-high reset
//     paddle_bus  pong_paddle_mover_if.slave: mode, buttons, ball row,
//                 pixel column/row in; draw flag, paddle Y, step pulse out
module pong_paddle_mover #(
  parameter int PADDLE_X      = 0,
  parameter int PADDLE_HEIGHT = 6,
  parameter int GAME_HEIGHT   = 30,
  parameter int COORD_W       = 6,
  parameter int SLOW_PERIOD   = 1250000,
  parameter int FAST_PERIOD   = 625000,
  parameter int RAMP_STEPS    = 4,
  parameter int CNT_W         = 22,
  parameter int RESET_Y       = (GAME_HEIGHT - PADDLE_HEIGHT) / 2
) (
  input logic               i_Clk,
  input logic               i_Rst,
  pong_paddle_mover_if.slave paddle_bus
);

  localparam int STEP_W = (RAMP_STEPS < 1) ? 1 : $clog2(RAMP_STEPS + 1);

  localparam logic [COORD_W-1:0] MAX_Y       = COORD_W'(GAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0] START_Y     = COORD_W'(RESET_Y);
  localparam logic [COORD_W-1:0] COL_X       = COORD_W'(PADDLE_X);
  localparam logic [COORD_W:0]   HALF_HEIGHT = (COORD_W+1)'(PADDLE_HEIGHT / 2);
  localparam logic [COORD_W:0]   FULL_HEIGHT = (COORD_W+1)'(PADDLE_HEIGHT);
  localparam logic [CNT_W-1:0]   SLOW_LAST   = CNT_W'(SLOW_PERIOD - 1);
  localparam logic [CNT_W-1:0]   FAST_LAST   = CNT_W'(FAST_PERIOD - 1);
  localparam logic [STEP_W-1:0]  RAMP_MAX    = STEP_W'(RAMP_STEPS);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DN} req_t;

  state_t             state, state_next;
  req_t               req;
  logic               dir_dn, dir_dn_next;
  logic [CNT_W-1:0]   cnt, cnt_next, period_last;
  logic [STEP_W-1:0]  steps, steps_next, steps_inc;
  logic [COORD_W-1:0] paddle_y, y_next;
  logic [COORD_W:0]   center;
  logic               mode_q, mode_changed;
  logic               req_same, period_done, at_limit, do_step;
  logic               step_q, draw_q, draw_next;

  // Turn the inputs into a single movement request. Auto mode compares the
  // ball row with the paddle centre one bit wider than the coordinates so
  // the sum can never wrap; the buttons are ignored there.
  always_comb begin
    req    = REQ_NONE;
    center = {1'b0, paddle_y} + HALF_HEIGHT;
    if (paddle_bus.i_Mode) begin
      if ({1'b0, paddle_bus.i_Ball_Y} < center) begin
        req = REQ_UP;
      end else if ({1'b0, paddle_bus.i_Ball_Y} > center) begin
        req = REQ_DN;
      end
    end else begin
      if (paddle_bus.i_Paddle_Up && !paddle_bus.i_Paddle_Dn) begin
        req = REQ_UP;
      end else if (paddle_bus.i_Paddle_Dn && !paddle_bus.i_Paddle_Up) begin
        req = REQ_DN;
      end
    end
  end

  // Shared decode used by both the next-state and output logic. A period
  // only completes while moving in the latched direction with no mode flip.
  assign mode_changed = (paddle_bus.i_Mode != mode_q);
  assign period_last  = (state == FAST) ? FAST_LAST : SLOW_LAST;
  assign req_same     = (req != REQ_NONE) && ((req == REQ_DN) == dir_dn);
  assign period_done  = (state != IDLE) && !mode_changed && req_same &&
                        (cnt == period_last);
  assign at_limit     = dir_dn ? (paddle_y == MAX_Y) : (paddle_y == '0);
  assign steps_inc    = (steps == RAMP_MAX) ? steps : steps + 1'b1;

  // State register plus every other piece of sequential state. Reset is
  // synchronous and wins over everything, including a step due that edge.
  // The mode is sampled during reset so leaving reset is not seen as a flip.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      dir_dn   <= 1'b0;
      cnt      <= '0;
      steps    <= '0;
      paddle_y <= START_Y;
      step_q   <= 1'b0;
      draw_q   <= 1'b0;
      mode_q   <= paddle_bus.i_Mode;
    end else begin
      state    <= state_next;
      dir_dn   <= dir_dn_next;
      cnt      <= cnt_next;
      steps    <= steps_next;
      paddle_y <= y_next;
      step_q   <= do_step;
      draw_q   <= draw_next;
      mode_q   <= paddle_bus.i_Mode;
    end
  end

  // Next-state logic for the speed ramp. Leaving IDLE only latches the
  // direction and starts the period, so a step can never coincide with it.
  // A blocked step at the travel limit leaves steps and state untouched.
  always_comb begin
    state_next  = state;
    dir_dn_next = dir_dn;
    cnt_next    = cnt;
    steps_next  = steps;
    if (mode_changed) begin
      state_next = IDLE;
      cnt_next   = '0;
      steps_next = '0;
    end else if (state == IDLE) begin
      if (req != REQ_NONE) begin
        dir_dn_next = (req == REQ_DN);
        cnt_next    = '0;
        steps_next  = '0;
        state_next  = SLOW;
      end
    end else if (req == REQ_NONE) begin
      state_next = IDLE;
      cnt_next   = '0;
      steps_next = '0;
    end else if (!req_same) begin
      dir_dn_next = (req == REQ_DN);
      cnt_next    = '0;
      steps_next  = '0;
      state_next  = SLOW;
    end else if (!period_done) begin
      cnt_next = cnt + 1'b1;
    end else begin
      cnt_next = '0;
      if (do_step) begin
        steps_next = steps_inc;
        if (steps_inc == RAMP_MAX) begin
          state_next = FAST;
        end
      end
    end
  end

  // Output logic: the actual Y move and the draw test. The draw test uses
  // the registered Y, so it reflects the paddle before any same-edge step.
  always_comb begin
    do_step = period_done && !at_limit;
    y_next  = paddle_y;
    if (do_step) begin
      y_next = dir_dn ? paddle_y + 1'b1 : paddle_y - 1'b1;
    end
    draw_next = (paddle_bus.i_Col_Count_Div == COL_X) &&
                (paddle_bus.i_Row_Count_Div >= paddle_y) &&
                ({1'b0, paddle_bus.i_Row_Count_Div} < ({1'b0, paddle_y} + FULL_HEIGHT));
  end

  assign paddle_bus.o_Paddle_Y    = paddle_y;
  assign paddle_bus.o_Step        = step_q;
  assign paddle_bus.o_Draw_Paddle = draw_q;

endmodule

// File: tb/tb_pong_paddle_mover.sv
// tb_pong_paddle_mover
//   Directed bench for pong_paddle_mover with SLOW=8, FAST=4, RAMP=2 and
//   default geometry (Y range 0..24, reset Y 12). Inputs change 1 time unit
//   after a rising edge and outputs are sampled at the same point.
module tb_pong_paddle_mover;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pong_paddle_mover_if #(.COORD_W(6)) bus ();

  pong_paddle_mover #(
    .SLOW_PERIOD(8),
    .FAST_PERIOD(4),
    .RAMP_STEPS(2)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .paddle_bus(bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst_v, input logic mode_v,
                               input logic up_v, input logic dn_v,
                               input logic [5:0] ball_v);
    rst             = rst_v;
    bus.i_Mode      = mode_v;
    bus.i_Paddle_Up = up_v;
    bus.i_Paddle_Dn = dn_v;
    bus.i_Ball_Y    = ball_v;
  endtask

  task automatic setPixel(input logic [5:0] col_v, input logic [5:0] row_v);
    bus.i_Col_Count_Div = col_v;
    bus.i_Row_Count_Div = row_v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    checks = 0;
    errors = 0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    setPixel(6'd0, 6'd0);
    tick(2);
    checkOutput("reset_y", bus.o_Paddle_Y, 12);
    checkOutput("reset_step", bus.o_Step, 0);
    checkOutput("reset_draw", bus.o_Draw_Paddle, 0);

    $display("[TB] hold up, slow then fast");
    setPixel(6'd0, 6'd7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    tick(8);
    checkOutput("up_before_first", bus.o_Paddle_Y, 12);
    tick(1);
    checkOutput("up_first_y", bus.o_Paddle_Y, 11);
    checkOutput("up_first_step", bus.o_Step, 1);
    tick(1);
    checkOutput("up_step_one_cycle", bus.o_Step, 0);
    checkOutput("up_hold_y", bus.o_Paddle_Y, 11);
    tick(6);
    checkOutput("up_before_second", bus.o_Paddle_Y, 11);
    tick(1);
    checkOutput("up_second_y", bus.o_Paddle_Y, 10);
    checkOutput("up_second_step", bus.o_Step, 1);
    tick(3);
    checkOutput("up_before_fast", bus.o_Paddle_Y, 10);
    tick(1);
    checkOutput("up_fast_y", bus.o_Paddle_Y, 9);
    checkOutput("up_fast_step", bus.o_Step, 1);
    tick(16);
    checkOutput("up_y5", bus.o_Paddle_Y, 5);
    checkOutput("draw_row7_y5", bus.o_Draw_Paddle, 1);

    $display("[TB] reset while fast");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    tick(1);
    checkOutput("midrst_y", bus.o_Paddle_Y, 12);
    checkOutput("midrst_step", bus.o_Step, 0);
    checkOutput("midrst_draw", bus.o_Draw_Paddle, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    tick(8);
    checkOutput("restart_slow_hold", bus.o_Paddle_Y, 12);
    tick(1);
    checkOutput("restart_slow_y", bus.o_Paddle_Y, 11);
    tick(48);
    checkOutput("up_top_y", bus.o_Paddle_Y, 0);
    checkOutput("up_top_step", bus.o_Step, 1);
    tick(8);
    checkOutput("up_limit_y", bus.o_Paddle_Y, 0);
    checkOutput("up_limit_step", bus.o_Step, 0);

    $display("[TB] both buttons");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
    tick(10);
    checkOutput("both_y", bus.o_Paddle_Y, 0);
    checkOutput("both_step", bus.o_Step, 0);

    $display("[TB] hold down to bottom limit");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick(97);
    checkOutput("dn_y22", bus.o_Paddle_Y, 22);
    tick(8);
    checkOutput("dn_y24", bus.o_Paddle_Y, 24);
    checkOutput("dn_y24_step", bus.o_Step, 1);
    tick(1);
    checkOutput("dn_y24_step_drop", bus.o_Step, 0);
    tick(12);
    checkOutput("dn_limit_y", bus.o_Paddle_Y, 24);
    checkOutput("dn_limit_step", bus.o_Step, 0);

    $display("[TB] direction reversal restarts slow period");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    tick(8);
    checkOutput("rev_up_hold", bus.o_Paddle_Y, 24);
    tick(1);
    checkOutput("rev_up_y", bus.o_Paddle_Y, 23);
    tick(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    tick(8);
    checkOutput("rev_dn_hold", bus.o_Paddle_Y, 23);
    tick(1);
    checkOutput("rev_dn_y", bus.o_Paddle_Y, 24);
    checkOutput("rev_dn_step", bus.o_Step, 1);

    $display("[TB] auto mode tracks ball");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 6'd20);
    tick(9);
    checkOutput("auto_hold", bus.o_Paddle_Y, 12);
    tick(1);
    checkOutput("auto_y13", bus.o_Paddle_Y, 13);
    checkOutput("auto_y13_step", bus.o_Step, 1);
    tick(8);
    checkOutput("auto_y14", bus.o_Paddle_Y, 14);
    tick(4);
    checkOutput("auto_y15", bus.o_Paddle_Y, 15);
    tick(8);
    checkOutput("auto_y17", bus.o_Paddle_Y, 17);
    tick(20);
    checkOutput("auto_stop_y", bus.o_Paddle_Y, 17);
    checkOutput("auto_stop_step", bus.o_Step, 0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd15);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd15);
    tick(20);
    checkOutput("auto_centered_y", bus.o_Paddle_Y, 12);
    checkOutput("auto_centered_step", bus.o_Step, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd14);
    tick(8);
    checkOutput("auto_up_hold", bus.o_Paddle_Y, 12);
    tick(1);
    checkOutput("auto_up_y", bus.o_Paddle_Y, 11);
    tick(20);
    checkOutput("auto_up_stop", bus.o_Paddle_Y, 11);

    $display("[TB] draw sweep");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    for (int r = 0; r < 30; r++) begin
      setPixel(6'd0, r[5:0]);
      tick(1);
      checkOutput("draw_col0", bus.o_Draw_Paddle, {31'b0, (r >= 12 && r <= 17)});
    end
    for (int r = 0; r < 30; r++) begin
      setPixel(6'd1, r[5:0]);
      tick(1);
      checkOutput("draw_col1", bus.o_Draw_Paddle, 0);
    end
    checkOutput("draw_sweep_y", bus.o_Paddle_Y, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
